// File: rtl/reg_file.sv
// Register file with combinational write-through reads, a per-register pending
// scoreboard driving stall, and a saturating count of committed writes.
`ifndef RegWidth
`define RegWidth 32
`endif

module reg_file #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [ADDR_W-1:0]    i_rd_addr1,
  input  logic [ADDR_W-1:0]    i_rd_addr2,
  output logic [`RegWidth-1:0] o_rd_data1,
  output logic [`RegWidth-1:0] o_rd_data2,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [`RegWidth-1:0] i_wr_data,
  input  logic                 i_busy_set,
  input  logic [ADDR_W-1:0]    i_busy_addr,
  output logic                 o_stall,
  output logic [15:0]          o_wr_count
);

  logic [`RegWidth-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]  r_pending;
  logic [15:0]          r_wr_count;

  logic [NUM_REGS-1:0]  w_pending_d;
  logic                 w_wr_commit;
  logic                 w_bypass1;
  logic                 w_bypass2;

  // Writes to index 0 are dropped everywhere, so fold that into one strobe.
  assign w_wr_commit = i_wr_en && (i_wr_addr != '0);
  assign w_bypass1   = w_wr_commit && (i_wr_addr == i_rd_addr1);
  assign w_bypass2   = w_wr_commit && (i_wr_addr == i_rd_addr2);

  always_comb begin
    o_rd_data1 = '0;
    if (i_rd_addr1 != '0) begin
      o_rd_data1 = w_bypass1 ? i_wr_data : r_regs[i_rd_addr1];
    end
  end

  always_comb begin
    o_rd_data2 = '0;
    if (i_rd_addr2 != '0) begin
      o_rd_data2 = w_bypass2 ? i_wr_data : r_regs[i_rd_addr2];
    end
  end

  // Set is applied after clear so a new issue supersedes a same-index completion.
  always_comb begin
    w_pending_d = r_pending;
    if (w_wr_commit) begin
      w_pending_d[i_wr_addr] = 1'b0;
    end
    if (i_busy_set) begin
      w_pending_d[i_busy_addr] = 1'b1;
    end
    w_pending_d[0] = 1'b0;
  end

  assign o_stall = (r_pending[i_rd_addr1] & ~w_bypass1) |
                   (r_pending[i_rd_addr2] & ~w_bypass2);

  assign o_wr_count = r_wr_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_pending  <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_wr_commit) begin
        r_regs[i_wr_addr] <= i_wr_data;
      end
      r_pending <= w_pending_d;
      if (w_wr_commit && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
- REQ-001 Parameter: NUM_REGS, 8, number of architectural registers; SHALL be a power of two, 2..16.
- REQ-002 Parameter: ADDR_W, 3, register index width; SHALL equal log2(NUM_REGS).
- REQ-003 Data width SHALL be `RegWidth (defs.svh) for all data ports.
- REQ-004 clk  input  1  sole clock; all state updates on rising edge.
- REQ-005 rst  input  1  reset, synchronous, active-high.
- REQ-006 rd_addr1  input  ADDR_W  read port 1 index; feeds ALU reg1.
- REQ-007 rd_addr2  input  ADDR_W  read port 2 index; feeds ALU reg2.
- REQ-008 rd_data1  output  `RegWidth  read port 1 data.
- REQ-009 rd_data2  output  `RegWidth  read port 2 data.
- REQ-010 wr_en  input  1  writeback strobe; takes ALU regOut.
- REQ-011 wr_addr  input  ADDR_W  writeback index.
- REQ-012 wr_data  input  `RegWidth  writeback data (ALU regOut).
- REQ-013 busy_set  input  1  mark rd_dst pending (instruction issued to ALU).
- REQ-014 busy_addr  input  ADDR_W  register to mark pending.
- REQ-015 stall  output  1  high when either read index is pending.
- REQ-016 wr_count  output  16  count of committed writes, saturating.

Function
- REQ-017 Register 0 SHALL read as 0 always; writes and busy_set to index 0 SHALL be ignored.
- REQ-018 Storage registers 1..NUM_REGS-1 SHALL update on rising clk when wr_en=1 and wr_addr matches.
- REQ-019 Read ports SHALL be combinational (zero-cycle latency) from rd_addr to rd_data.
- REQ-020 Write-through bypass: when wr_en=1 and wr_addr==rd_addrN!=0 in the same cycle, rd_dataN SHALL equal wr_data.
- REQ-021 Scoreboard: one pending bit per register; busy_set=1 SHALL set bit[busy_addr] on next edge.
- REQ-022 wr_en=1 SHALL clear bit[wr_addr] on next edge.
- REQ-023 busy_set and wr_en same cycle, same index: set SHALL win (new issue supersedes completion).
- REQ-024 busy_set and wr_en same cycle, different indices: both updates SHALL apply.
- REQ-025 stall SHALL be combinational: (pending[rd_addr1] & ~bypass1) | (pending[rd_addr2] & ~bypass2), where bypassN = wr_en & wr_addr==rd_addrN.
- REQ-026 Index 0 SHALL never contribute to stall.
- REQ-027 wr_count SHALL increment by 1 per edge with wr_en=1 and wr_addr!=0; SHALL hold at 16'hFFFF (no wrap).
- REQ-028 Simultaneous rd_addr1==rd_addr2 SHALL return identical data on both ports.

Reset
- REQ-029 rst=1 at an edge SHALL clear all registers to 0, all pending bits to 0, wr_count to 0.
- REQ-030 rst SHALL take priority over wr_en and busy_set in the same cycle; those writes SHALL be discarded.
- REQ-031 After reset, rd_data1=rd_data2=0 and stall=0 until a write or busy_set occurs.

Verification
- REQ-032 Reset, write r3=2, r5=3, read rd_addr1=3, rd_addr2=5 -> rd_data1=2, rd_data2=3 (ALU add input gives 5).
- REQ-033 wr_en=1, wr_addr=4, wr_data='h10, rd_addr1=4 same cycle -> rd_data1='h10 before the edge (bypass).
- REQ-034 Write r0='hFF -> rd_data1 with rd_addr1=0 stays 0; wr_count unchanged.
- REQ-035 busy_set r2, next cycle rd_addr2=2 -> stall=1; wr_en r2 data 7 -> stall=0 that cycle, rd_data2=7; pending clear after edge.
- REQ-036 busy_set r6 and wr_en r6 same cycle -> r6 still pending, stall=1 on rd_addr1=6.
- REQ-037 Write r1=9, busy_set r1, then rst with wr_en r1=5 -> r1=0, stall=0, wr_count=0.
